load_register_file: RTL and testbench
=====================================

LOAD_REGISTER_FILE -- requirements
Module: load_register_file

Interface
REQ-001 Parameter WIDTH, default 32: bit width of each register and of every data port.
REQ-002 Parameter ADDR_W, default 5: address width; register count DEPTH = 2**ADDR_W.
REQ-003 CLK  input  1  sole clock; all state changes on the rising edge.
REQ-004 RST_N  input  1  reset, synchronous, active-low; sampled on the rising edge of CLK.
REQ-005 L  input  1  write/load enable.
REQ-006 WA  input  ADDR_W  write address.
REQ-007 D  input  WIDTH  write data.
REQ-008 RA1  input  ADDR_W  read address, port 1.
REQ-009 RA2  input  ADDR_W  read address, port 2.
REQ-010 Q1  output  WIDTH  read data, port 1.
REQ-011 Q2  output  WIDTH  read data, port 2.

Function
REQ-012 The block SHALL hold DEPTH registers of WIDTH bits; register 0 SHALL be hardwired to zero.
REQ-013 On a rising CLK edge with RST_N=1, L=1, WA!=0: reg[WA] SHALL take D; no other register changes.
REQ-014 L=1 with WA=0 SHALL be accepted and discarded; no register changes.
REQ-015 L=0 SHALL leave all registers unchanged (hold).
REQ-016 Reads SHALL be combinational: Q1 = reg[RA1], Q2 = reg[RA2]; zero cycles of latency from an address change.
REQ-017 RA1=0 or RA2=0 SHALL always return all-zeros, independent of L, WA, D.
REQ-018 Both read ports SHALL be independent; RA1=RA2 SHALL return identical values.
REQ-019 A write SHALL become visible on Q1/Q2 no later than immediately after the rising edge that performs it.
REQ-020 Data width SHALL be exact; no truncation, sign extension or padding of D.
REQ-021 Back-to-back writes to the same address on consecutive edges: last write wins, each visible for its cycle.

Reset
REQ-022 RST_N=0 at a rising edge SHALL clear every register to 0, regardless of L, WA, D.
REQ-023 Reset SHALL dominate write: RST_N=0 with L=1 SHALL leave all registers 0 after the edge.
REQ-024 RST_N=0 between edges SHALL have no effect until the next rising edge (synchronous).
REQ-025 After the reset edge, Q1 and Q2 SHALL read 0 for every address until a write occurs.
REQ-026 Reset mid-sequence SHALL discard all prior writes; the first write after RST_N returns to 1 takes effect normally.

Configuration
REQ-027 Macro REGFILE_BYPASS_EN SHALL control write-to-read forwarding.
REQ-028 With REGFILE_BYPASS_EN defined: when RST_N=1, L=1, WA!=0 and RAx=WA, Qx SHALL equal D in the same cycle (before the edge).
REQ-029 With REGFILE_BYPASS_EN defined: no forwarding when RST_N=0, L=0 or WA=0; Qx then reads stored value.
REQ-030 Without REGFILE_BYPASS_EN: Qx SHALL show the old reg[RAx] until the write edge, the new value after it.

Verification (WIDTH=32, ADDR_W=5)
REQ-031 RST_N=0 one edge, then sweep RA1/RA2 over 0..31 -> Q1=Q2=32'h0 for every address.
REQ-032 L=1, WA=5, D=32'hDEADBEEF, one edge; L=0; RA1=5, RA2=5 -> Q1=Q2=32'hDEADBEEF; RA1=6 -> Q1=0.
REQ-033 L=1, WA=0, D=32'hFFFFFFFF, one edge; RA1=0 -> Q1=32'h0.
REQ-034 reg[7]=32'h11111111; L=1, WA=7, D=32'h22222222, RA1=7 before edge -> Q1=32'h22222222 with REGFILE_BYPASS_EN, 32'h11111111 without; after edge both 32'h22222222.
REQ-035 reg[3]=32'hA5A5A5A5; RST_N=0, L=1, WA=3, D=32'h5A5A5A5A, one edge -> reg[3]=0; RST_N=1 next edge same write -> Q1(RA1=3)=32'h5A5A5A5A.
REQ-036 L=0, WA=9, D=32'h12345678 for 3 edges -> reg[9] unchanged at 0.

Source files
------------

// File: rtl/load_register_file.sv
// rtl/load_register_file.sv - DEPTH x WIDTH register file, one write port, two combinational read ports.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module load_register_file #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              L,
  input  logic [ADDR_W-1:0] WA,
  input  logic [WIDTH-1:0]  D,
  input  logic [ADDR_W-1:0] RA1,
  input  logic [ADDR_W-1:0] RA2,
  output logic [WIDTH-1:0]  Q1,
  output logic [WIDTH-1:0]  Q2
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [WIDTH-1:0] regs [DEPTH];
  logic             wr_en;

  assign wr_en = L && (WA != '0);

  // Entry 0 is only ever cleared by reset; reads of address 0 are forced to zero regardless.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[WA] <= D;
    end
  end

  always_comb begin
    Q1 = '0;
    Q2 = '0;
    if (RA1 != '0) begin
      Q1 = regs[RA1];
    end
    if (RA2 != '0) begin
      Q2 = regs[RA2];
    end
`ifdef REGFILE_BYPASS_EN
    // Forward the pending write so readers see it before the edge commits it.
    if (RST_N && wr_en && (RA1 == WA)) begin
      Q1 = D;
    end
    if (RST_N && wr_en && (RA2 == WA)) begin
      Q2 = D;
    end
`endif
  end

endmodule

// File: tb/tb_load_register_file.sv
// tb/tb_load_register_file.sv - self-checking bench for load_register_file against an array reference model.
module tb_load_register_file;

  localparam int WIDTH  = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;

  logic              CLK = 1'b0;
  logic              RST_N;
  logic              L;
  logic [ADDR_W-1:0] WA;
  logic [WIDTH-1:0]  D;
  logic [ADDR_W-1:0] RA1;
  logic [ADDR_W-1:0] RA2;
  logic [WIDTH-1:0]  Q1;
  logic [WIDTH-1:0]  Q2;

  logic [WIDTH-1:0] model [DEPTH];
  int errors = 0;
  int checks = 0;

  load_register_file #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .CLK(CLK), .RST_N(RST_N), .L(L), .WA(WA), .D(D),
    .RA1(RA1), .RA2(RA2), .Q1(Q1), .Q2(Q2)
  );

  always #5 CLK = ~CLK;

  // What a reader should see right now, given stored contents and the pending inputs.
  function automatic logic [WIDTH-1:0] exp_read(input logic [ADDR_W-1:0] ra);
    if (ra == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (RST_N === 1'b1 && L === 1'b1 && WA != 0 && ra == WA) return D;
`endif
    return model[ra];
  endfunction

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_ports(input string tag);
    #1;
    check({tag, "_q1"}, Q1, exp_read(RA1));
    check({tag, "_q2"}, Q2, exp_read(RA2));
  endtask

  // One rising edge; the model commits whatever the inputs say at that edge.
  task automatic step();
    @(posedge CLK);
    if (RST_N !== 1'b1) begin
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
    end else if (L === 1'b1 && WA != 0) begin
      model[WA] = D;
    end
    #1;
  endtask

  task automatic write(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] v);
    L = 1'b1; WA = a; D = v;
    step();
    L = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) model[i] = 'x;
    RST_N = 1'b0; L = 1'b1; WA = 5'd4; D = 32'hCAFEF00D; RA1 = '0; RA2 = '0;
    step();
    L = 1'b0;
    RST_N = 1'b1;

    // Every address reads zero after reset.
    for (int a = 0; a < DEPTH; a++) begin
      RA1 = a[ADDR_W-1:0]; RA2 = 5'(DEPTH - 1 - a);
      #1;
      check("reset_sweep_q1", Q1, 32'h0);
      check("reset_sweep_q2", Q2, 32'h0);
    end

    write(5'd5, 32'hDEADBEEF);
    RA1 = 5'd5; RA2 = 5'd5; #1;
    check("wr5_q1", Q1, 32'hDEADBEEF);
    check("wr5_q2", Q2, 32'hDEADBEEF);
    RA1 = 5'd6; #1;
    check("rd6_zero", Q1, 32'h0);

    write(5'd0, 32'hFFFFFFFF);
    RA1 = 5'd0; RA2 = 5'd0; #1;
    check("wr0_discard_q1", Q1, 32'h0);
    check("wr0_discard_q2", Q2, 32'h0);

    write(5'd7, 32'h11111111);
    L = 1'b1; WA = 5'd7; D = 32'h22222222; RA1 = 5'd7; RA2 = 5'd0; #1;
`ifdef REGFILE_BYPASS_EN
    check("pre_edge_7", Q1, 32'h22222222);
`else
    check("pre_edge_7", Q1, 32'h11111111);
`endif
    check("pre_edge_ra0", Q2, 32'h0);
    step();
    check("post_edge_7", Q1, 32'h22222222);
    L = 1'b0;

    write(5'd3, 32'hA5A5A5A5);
    RST_N = 1'b0; L = 1'b1; WA = 5'd3; D = 32'h5A5A5A5A; RA1 = 5'd3; RA2 = 5'd5; #1;
    check("rst_no_bypass", Q1, 32'hA5A5A5A5);
    step();
    check("rst_dominates_3", Q1, 32'h0);
    check("rst_clears_5", Q2, 32'h0);
    RST_N = 1'b1;
    step();
    check("after_rst_write_3", Q1, 32'h5A5A5A5A);
    L = 1'b0;

    L = 1'b0; WA = 5'd9; D = 32'h12345678; RA1 = 5'd9; RA2 = 5'd9;
    for (int k = 0; k < 3; k++) begin
      step();
      check("hold_9_q1", Q1, 32'h0);
      check("hold_9_q2", Q2, 32'h0);
    end

    // Reset pulsed between edges has no effect.
    write(5'd12, 32'h0BADC0DE);
    RA1 = 5'd12; @(negedge CLK); RST_N = 1'b0; #2;
    check("async_glitch_12", Q1, 32'h0BADC0DE);
    RST_N = 1'b1;
    step();
    check("glitch_no_clear_12", Q1, 32'h0BADC0DE);

    // Back-to-back writes to one address.
    RA1 = 5'd20; RA2 = 5'd20;
    L = 1'b1; WA = 5'd20;
    D = 32'h00000001; step(); check("b2b_1", Q1, 32'h00000001);
    D = 32'h80000000; step(); check("b2b_2", Q2, 32'h80000000);
    L = 1'b0; #1; check("b2b_last", Q1, 32'h80000000);

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      RST_N = ($urandom_range(0, 39) != 0);
      L     = $urandom_range(0, 2) != 0;
      WA    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      D     = $urandom;
      RA1   = ($urandom_range(0, 3) == 0) ? WA : 5'($urandom);
      RA2   = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      check_ports("rand_pre");
      @(negedge CLK);
      step();
      check_ports("rand_post");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: bench did not complete");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
